// File: rtl/adder_arbiter_if.sv
// -----------------------------------------------------------------------------
// adder_arbiter_if
//
// Bundles every bus-level signal of adder_arbiter: the per-requester operand
// handshake, the result handshake, the shared-adder connection and the busy
// status flag.
//
// Modports:
//   slave  - the arbiter. It accepts requests, drives the shared adder
//            operands and produces responses.
//   master - the surrounding system. It drives requests, consumes responses
//            and returns the combinational adder sum.
//
// Signals:
//   io_req_valid  [NUM_REQ]        per-requester request valid
//   io_req_ready  [NUM_REQ]        per-requester accept, at most one bit high
//   io_req_a      [NUM_REQ*WIDTH]  packed operand A, requester i at [i*WIDTH +: WIDTH]
//   io_req_b      [NUM_REQ*WIDTH]  packed operand B, same packing
//   io_resp_valid                  result available
//   io_resp_ready                  consumer accepts the result
//   io_resp_id    [ID_W]           requester that owns the result
//   io_resp_sum   [WIDTH]          (a+b) mod 2^WIDTH
//   io_adder_a    [WIDTH]          operand A to the shared adder
//   io_adder_b    [WIDTH]          operand B to the shared adder
//   io_adder_sum  [WIDTH]          combinational sum from the shared adder
//   io_busy                        arbiter is not idle
// -----------------------------------------------------------------------------
interface adder_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ID_W    = 2
);

   logic [NUM_REQ-1:0]       io_req_valid;
   logic [NUM_REQ-1:0]       io_req_ready;
   logic [NUM_REQ*WIDTH-1:0] io_req_a;
   logic [NUM_REQ*WIDTH-1:0] io_req_b;
   logic                     io_resp_valid;
   logic                     io_resp_ready;
   logic [ID_W-1:0]          io_resp_id;
   logic [WIDTH-1:0]         io_resp_sum;
   logic [WIDTH-1:0]         io_adder_a;
   logic [WIDTH-1:0]         io_adder_b;
   logic [WIDTH-1:0]         io_adder_sum;
   logic                     io_busy;

   modport slave (
      input  io_req_valid,
      input  io_req_a,
      input  io_req_b,
      input  io_resp_ready,
      input  io_adder_sum,
      output io_req_ready,
      output io_resp_valid,
      output io_resp_id,
      output io_resp_sum,
      output io_adder_a,
      output io_adder_b,
      output io_busy
   );

   modport master (
      output io_req_valid,
      output io_req_a,
      output io_req_b,
      output io_resp_ready,
      output io_adder_sum,
      input  io_req_ready,
      input  io_resp_valid,
      input  io_resp_id,
      input  io_resp_sum,
      input  io_adder_a,
      input  io_adder_b,
      input  io_busy
   );

endinterface

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Round-robin arbiter and sequencer that time-shares one external
// combinational adder among NUM_REQ requesters. A granted requester's operands
// are registered, presented to the shared adder for one cycle, the sum is
// captured and returned with the requester index over a valid/ready response
// channel.
//
// Sequence: IDLE (grant + latch operands) -> EXEC (capture adder sum)
//           -> RESP (hold result until accepted) -> IDLE.
// A request accepted in cycle T yields io_resp_valid in cycle T+2.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; discards any in-flight transaction
//   bus    - adder_arbiter_if slave modport (request, response, adder, busy)
// -----------------------------------------------------------------------------
module adder_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input logic           clock,
   input logic           reset,
   adder_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [ID_W-1:0]    id_q, id_d;

   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;
   logic [NUM_REQ-1:0] req_ready;

   // Round-robin search starting at ptr_q; first valid requester wins.
   always_comb begin
      logic [ID_W-1:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         cand = ID_W'((int'(ptr_q) + k) % int'(NUM_REQ));
         if (!grant_found && bus.io_req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant_idx == ID_W'(i)) begin
            a_sel = bus.io_req_a[i*WIDTH +: WIDTH];
            b_sel = bus.io_req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state and request-side outputs.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      id_d      = id_q;
      req_ready = '0;

      unique case (state_q)
         StIdle: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               a_d                  = a_sel;
               b_d                  = b_sel;
               id_d                 = grant_idx;
               ptr_d                = ID_W'((int'(grant_idx) + 1) % int'(NUM_REQ));
               state_d              = StExec;
            end
         end
         StExec: begin
            sum_d   = bus.io_adder_sum;
            state_d = StResp;
         end
         StResp: begin
            if (bus.io_resp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
      end
   end

   // Suppress accepts while reset is asserted: the grant would not be latched,
   // so the requester must not see a completed handshake.
   assign bus.io_req_ready  = reset ? '0 : req_ready;
   assign bus.io_resp_valid = (state_q == StResp);
   assign bus.io_resp_id    = id_q;
   assign bus.io_resp_sum   = sum_q;
   assign bus.io_adder_a    = a_q;
   assign bus.io_adder_b    = b_q;
   assign bus.io_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Directed bench for adder_arbiter. Inputs change 1 ns after a rising edge,
// outputs are sampled on the falling edge. The shared adder is modelled here.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned ID_W    = 2;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   int   cyc;

   adder_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

   adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.io_adder_sum = bus.io_adder_a + bus.io_adder_b;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      bus.io_req_a[i*32 +: 32] = a;
      bus.io_req_b[i*32 +: 32] = b;
   endtask

   // Ends on the falling edge where io_resp_valid is seen, or after the bound.
   task automatic wait_resp(output bit ok);
      int n;
      n = 0;
      @(negedge clock);
      while (bus.io_resp_valid !== 1'b1 && n < 8) begin
         @(negedge clock);
         n++;
      end
      ok = (bus.io_resp_valid === 1'b1);
   endtask

   task automatic test_reset();
      reset              = 1'b1;
      bus.io_req_valid   = 4'b1111;
      bus.io_resp_ready  = 1'b1;
      bus.io_req_a       = '0;
      bus.io_req_b       = '0;
      step();
      step();
      @(negedge clock);
      checks++;
      if (bus.io_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b exp 0", bus.io_busy);
      end
      checks++;
      if (bus.io_resp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.io_resp_valid);
      end
      checks++;
      if (bus.io_req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.io_req_ready);
      end
      checks++;
      if (bus.io_resp_id !== 2'd0 || bus.io_resp_sum !== 32'd0) begin
         errors++;
         $display("FAIL reset_resp got id=%0d sum=%h exp id=0 sum=0",
                  bus.io_resp_id, bus.io_resp_sum);
      end
      checks++;
      if (bus.io_adder_a !== 32'd0 || bus.io_adder_b !== 32'd0) begin
         errors++;
         $display("FAIL reset_adder got a=%h b=%h exp 0 0", bus.io_adder_a, bus.io_adder_b);
      end
      step();
      reset            = 1'b0;
      bus.io_req_valid = 4'b0000;
   endtask

   task automatic test_single();
      set_ops(2, 32'd5, 32'd7);
      bus.io_req_valid = 4'b0100;
      @(negedge clock);
      checks++;
      if (bus.io_req_ready !== 4'b0100 || bus.io_busy !== 1'b0) begin
         errors++;
         $display("FAIL single_accept got ready=%b busy=%b exp ready=0100 busy=0",
                  bus.io_req_ready, bus.io_busy);
      end
      step();
      bus.io_req_valid = 4'b0000;
      @(negedge clock);
      checks++;
      if (bus.io_busy !== 1'b1 || bus.io_resp_valid !== 1'b0 || bus.io_req_ready !== 4'b0) begin
         errors++;
         $display("FAIL single_exec got busy=%b rv=%b ready=%b exp busy=1 rv=0 ready=0000",
                  bus.io_busy, bus.io_resp_valid, bus.io_req_ready);
      end
      checks++;
      if (bus.io_adder_a !== 32'd5 || bus.io_adder_b !== 32'd7) begin
         errors++;
         $display("FAIL single_adder got a=%0d b=%0d exp 5 7", bus.io_adder_a, bus.io_adder_b);
      end
      step();
      @(negedge clock);
      checks++;
      if (bus.io_resp_valid !== 1'b1 || bus.io_resp_id !== 2'd2 || bus.io_resp_sum !== 32'd12)
      begin
         errors++;
         $display("FAIL single_resp got rv=%b id=%0d sum=%0d exp rv=1 id=2 sum=12",
                  bus.io_resp_valid, bus.io_resp_id, bus.io_resp_sum);
      end
      step();
      @(negedge clock);
      checks++;
      if (bus.io_busy !== 1'b0 || bus.io_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got busy=%b rv=%b exp 0 0", bus.io_busy, bus.io_resp_valid);
      end
      step();
   endtask

   task automatic test_round_robin();
      bit ok;
      int last;
      logic [1:0] exp_id;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_ops(i, 32'(i), 32'd100);
      bus.io_req_valid  = 4'b1111;
      bus.io_resp_ready = 1'b1;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         exp_id = 2'(k % 4);
         wait_resp(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL rr_timeout got rv=%b exp 1", bus.io_resp_valid);
         end
         checks++;
         if (bus.io_resp_id !== exp_id || bus.io_resp_sum !== 32'(100 + k % 4)) begin
            errors++;
            $display("FAIL rr_resp%0d got id=%0d sum=%0d exp id=%0d sum=%0d", k,
                     bus.io_resp_id, bus.io_resp_sum, exp_id, 100 + k % 4);
         end
         if (k > 0) begin
            checks++;
            if (cyc - last != 3) begin
               errors++; $display("FAIL rr_interval%0d got %0d exp 3", k, cyc - last);
            end
         end
         last = cyc;
         step();
      end
      bus.io_req_valid = 4'b0000;
   endtask

   task automatic test_overflow();
      bit ok;
      set_ops(0, 32'hFFFF_FFFF, 32'h0000_0001);
      bus.io_req_valid = 4'b0001;
      wait_resp(ok);
      checks++;
      if (!ok || bus.io_resp_id !== 2'd0 || bus.io_resp_sum !== 32'h0) begin
         errors++;
         $display("FAIL overflow got ok=%b id=%0d sum=%h exp ok=1 id=0 sum=00000000",
                  ok, bus.io_resp_id, bus.io_resp_sum);
      end
      step();
      bus.io_req_valid = 4'b0000;
   endtask

   task automatic test_backpressure();
      bit ok;
      set_ops(3, 32'd1000, 32'd1);
      set_ops(1, 32'd40, 32'd2);
      bus.io_resp_ready = 1'b0;
      bus.io_req_valid  = 4'b1000;
      @(negedge clock);
      checks++;
      if (bus.io_req_ready !== 4'b1000) begin
         errors++; $display("FAIL bp_grant3 got %b exp 1000", bus.io_req_ready);
      end
      step();
      bus.io_req_valid = 4'b0010;
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         checks++;
         if (bus.io_resp_valid !== 1'b1 || bus.io_resp_id !== 2'd3 ||
             bus.io_resp_sum !== 32'd1001 || bus.io_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold%0d got rv=%b id=%0d sum=%0d ready=%b exp 1 3 1001 0000",
                     c, bus.io_resp_valid, bus.io_resp_id, bus.io_resp_sum, bus.io_req_ready);
         end
         step();
      end
      bus.io_resp_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.io_resp_valid !== 1'b1 || bus.io_req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL bp_release got rv=%b ready=%b exp 1 0000",
                  bus.io_resp_valid, bus.io_req_ready);
      end
      step();
      @(negedge clock);
      checks++;
      if (bus.io_req_ready !== 4'b0010) begin
         errors++; $display("FAIL bp_grant1 got %b exp 0010", bus.io_req_ready);
      end
      step();
      bus.io_req_valid = 4'b0000;
      wait_resp(ok);
      checks++;
      if (!ok || bus.io_resp_id !== 2'd1 || bus.io_resp_sum !== 32'd42) begin
         errors++;
         $display("FAIL bp_resp1 got ok=%b id=%0d sum=%0d exp 1 1 42",
                  ok, bus.io_resp_id, bus.io_resp_sum);
      end
      step();
   endtask

   task automatic test_wrap();
      bit ok;
      set_ops(3, 32'd7, 32'd8);
      bus.io_req_valid = 4'b1000;
      wait_resp(ok);
      checks++;
      if (!ok || bus.io_resp_id !== 2'd3 || bus.io_resp_sum !== 32'd15) begin
         errors++;
         $display("FAIL wrap_first got ok=%b id=%0d sum=%0d exp 1 3 15",
                  ok, bus.io_resp_id, bus.io_resp_sum);
      end
      step();
      set_ops(1, 32'd1, 32'd2);
      set_ops(3, 32'd3, 32'd4);
      bus.io_req_valid = 4'b1010;
      @(negedge clock);
      checks++;
      if (bus.io_req_ready !== 4'b0010) begin
         errors++; $display("FAIL wrap_grant1 got %b exp 0010", bus.io_req_ready);
      end
      step();
      wait_resp(ok);
      checks++;
      if (!ok || bus.io_resp_id !== 2'd1 || bus.io_resp_sum !== 32'd3) begin
         errors++;
         $display("FAIL wrap_resp1 got ok=%b id=%0d sum=%0d exp 1 1 3",
                  ok, bus.io_resp_id, bus.io_resp_sum);
      end
      step();
      @(negedge clock);
      checks++;
      if (bus.io_req_ready !== 4'b1000) begin
         errors++; $display("FAIL wrap_grant3 got %b exp 1000", bus.io_req_ready);
      end
      step();
      bus.io_req_valid = 4'b0000;
      wait_resp(ok);
      checks++;
      if (!ok || bus.io_resp_id !== 2'd3 || bus.io_resp_sum !== 32'd7) begin
         errors++;
         $display("FAIL wrap_resp3 got ok=%b id=%0d sum=%0d exp 1 3 7",
                  ok, bus.io_resp_id, bus.io_resp_sum);
      end
      step();
   endtask

   task automatic test_reset_exec();
      bit ok;
      bit seen;
      set_ops(2, 32'd9, 32'd9);
      bus.io_req_valid = 4'b0100;
      @(negedge clock);
      checks++;
      if (bus.io_req_ready !== 4'b0100) begin
         errors++; $display("FAIL rst_grant2 got %b exp 0100", bus.io_req_ready);
      end
      step();
      bus.io_req_valid = 4'b0000;
      reset            = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.io_busy !== 1'b1 || bus.io_adder_a !== 32'd9) begin
         errors++;
         $display("FAIL rst_in_exec got busy=%b a=%0d exp 1 9", bus.io_busy, bus.io_adder_a);
      end
      step();
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.io_busy !== 1'b0 || bus.io_resp_valid !== 1'b0 || bus.io_adder_a !== 32'd0) begin
         errors++;
         $display("FAIL rst_after got busy=%b rv=%b a=%h exp 0 0 0",
                  bus.io_busy, bus.io_resp_valid, bus.io_adder_a);
      end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (bus.io_resp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL rst_no_resp got resp_valid=1 exp 0");
      end
      step();
      set_ops(0, 32'd20, 32'd22);
      bus.io_req_valid = 4'b1111;
      @(negedge clock);
      checks++;
      if (bus.io_req_ready !== 4'b0001) begin
         errors++; $display("FAIL rst_ptr0 got %b exp 0001", bus.io_req_ready);
      end
      step();
      bus.io_req_valid = 4'b0000;
      wait_resp(ok);
      checks++;
      if (!ok || bus.io_resp_id !== 2'd0 || bus.io_resp_sum !== 32'd42) begin
         errors++;
         $display("FAIL rst_resp0 got ok=%b id=%0d sum=%0d exp 1 0 42",
                  ok, bus.io_resp_id, bus.io_resp_sum);
      end
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_overflow();
      test_backpressure();
      test_wrap();
      test_reset_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
